// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exec_pkg
// Purpose  : Shared opcodes, FSM state encoding and helpers for muldiv_seq.
// Revision : 1.0 - initial release
// ============================================================================
package exec_pkg;

  localparam logic [3:0] C_OP_DIV   = 4'b0100;
  localparam logic [3:0] C_OP_UMULL = 4'b0101;
  localparam logic [3:0] C_OP_SMULL = 4'b0110;
  localparam logic [3:0] C_OP_MUL32 = 4'b0111;

  localparam int C_ITER_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic op_supported(input logic [3:0] op);
    return (op == C_OP_DIV) || (op == C_OP_UMULL) ||
           (op == C_OP_SMULL) || (op == C_OP_MUL32);
  endfunction

  // Read as unsigned, the negation of 32'h80000000 is its exact magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] a);
    return a[31] ? (~a + 32'd1) : a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_if
// Purpose  : Request/result bundle between a requester and muldiv_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_seq_if;
  logic        start;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] ResultLo;
  logic [31:0] ResultHi;
  logic        DivByZero;

  modport master (
    output start, ALUControl, SrcA, SrcB,
    input  busy, done, ResultLo, ResultHi, DivByZero
  );

  modport slave (
    input  start, ALUControl, SrcA, SrcB,
    output busy, done, ResultLo, ResultHi, DivByZero
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : One radix-2 iteration: shift-add multiply or restoring divide.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step (
  input  logic        is_div,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o
);

  logic [32:0] w_add_sum;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;

  // Multiply: acc = {partial product high, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  always_comb begin
    w_add_sum = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
    w_rem_sh  = {acc_i[63:32], acc_i[31]};
    w_diff    = w_rem_sh - {1'b0, opnd_i};
    if (is_div) begin
      if (w_diff[32]) begin
        acc_o = {w_rem_sh[31:0], acc_i[30:0], 1'b0};
      end else begin
        acc_o = {w_diff[31:0], acc_i[30:0], 1'b1};
      end
    end else begin
      acc_o = {w_add_sum, acc_i[31:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Iterative 32x32 multiplier / unsigned divider, one step per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq
  import exec_pkg::*;
#(
  parameter int ITER = C_ITER_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(ITER - 1);

  state_t            state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [3:0]        op_q,     op_d;
  logic              neg_q,    neg_d;
  logic [31:0]       opnd_q,   opnd_d;
  logic [63:0]       acc_q,    acc_d;
  logic [31:0]       res_lo_q, res_lo_d;
  logic [31:0]       res_hi_q, res_hi_d;
  logic              dbz_q,    dbz_d;

  logic        w_accept;
  logic        w_div_zero;
  logic        w_is_smull;
  logic [63:0] w_step_acc;
  logic [63:0] w_prod;
  logic        w_busy;
  logic        w_done;

  assign w_accept   = (state_q == ST_IDLE) && bus.start && op_supported(bus.ALUControl);
  assign w_div_zero = (bus.ALUControl == C_OP_DIV) && (bus.SrcB == 32'd0);
  assign w_is_smull = (bus.ALUControl == C_OP_SMULL);
  assign w_prod     = neg_q ? (~acc_q + 64'd1) : acc_q;

  muldiv_step u_step (
    .is_div (op_q == C_OP_DIV),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (w_step_acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept) state_d = w_div_zero ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == C_CNT_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (state_q != ST_IDLE);
    w_done = (state_q == ST_DONE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          cnt_d = '0;
          op_d  = bus.ALUControl;
          dbz_d = 1'b0;
          neg_d = w_is_smull && (bus.SrcA[31] ^ bus.SrcB[31]);
          if (bus.ALUControl == C_OP_DIV) begin
            opnd_d = bus.SrcB;
            acc_d  = {32'd0, bus.SrcA};
            // Zero divisor finishes immediately with all-ones quotient.
            if (w_div_zero) begin
              res_lo_d = 32'hFFFF_FFFF;
              res_hi_d = bus.SrcA;
              dbz_d    = 1'b1;
            end
          end else begin
            opnd_d = w_is_smull ? abs32(bus.SrcA) : bus.SrcA;
            acc_d  = {32'd0, (w_is_smull ? abs32(bus.SrcB) : bus.SrcB)};
          end
        end
      end
      ST_CALC: begin
        acc_d = w_step_acc;
        cnt_d = cnt_q + 1'b1;
      end
      ST_FIX: begin
        res_lo_d = w_prod[31:0];
        res_hi_d = (op_q == C_OP_MUL32) ? 32'd0 : w_prod[63:32];
      end
      default: ;
    endcase
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.ResultLo  = res_lo_q;
  assign bus.ResultHi  = res_hi_q;
  assign bus.DivByZero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Directed-vector self-checking bench for muldiv_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
  import exec_pkg::*;

  localparam int MAX_WAIT = 60;
  localparam int NVEC     = 15;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          lat;
    int          poke;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs [NVEC];

  muldiv_seq_if bus ();

  muldiv_seq #(.ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start      = 1'b1;
    bus.ALUControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Called at cycle 1 after the accepting edge; returns the cycle done is seen.
  task automatic wait_done(input int poke, output int lat, output bit busy_ok);
    int k = 1;
    busy_ok = 1'b1;
    while (!bus.done && k <= MAX_WAIT) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (poke != 0 && k == poke) begin
        bus.start      = 1'b1;
        bus.ALUControl = C_OP_MUL32;
        bus.SrcA       = 32'd2;
        bus.SrcB       = 32'd3;
      end
      @(posedge clk); #1;
      if (poke != 0 && k == poke) bus.start = 1'b0;
      k++;
    end
    if (!bus.busy) busy_ok = 1'b0;
    lat = k;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit busy_ok;
    issue(v.op, v.a, v.b);
    wait_done(v.poke, lat, busy_ok);
    chk({tag, ".latency"}, 64'(lat), 64'(v.lat));
    chk({tag, ".busy"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, ".lo"}, {32'd0, bus.ResultLo}, {32'd0, v.lo});
    chk({tag, ".hi"}, {32'd0, bus.ResultHi}, {32'd0, v.hi});
    chk({tag, ".dbz"}, {63'd0, bus.DivByZero}, {63'd0, v.dbz});
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
    chk({tag, ".hold"}, {bus.ResultHi, bus.ResultLo}, {v.hi, v.lo});
  endtask

  initial begin
    int  lat;
    bit  busy_ok;
    bit  quiet;
    vec_t v;

    checks = 0;
    errors = 0;
    vecs[0]  = '{C_OP_MUL32, 32'd7,          32'd6,          32'd42,         32'd0,          1'b0, 34, 0};
    vecs[1]  = '{C_OP_UMULL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFE,  1'b0, 34, 0};
    vecs[2]  = '{C_OP_SMULL, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  32'hFFFF_FFFF,  1'b0, 34, 0};
    vecs[3]  = '{C_OP_SMULL, 32'h8000_0000,  32'd2,          32'h0000_0000,  32'hFFFF_FFFF,  1'b0, 34, 0};
    vecs[4]  = '{C_OP_DIV,   32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34, 10};
    vecs[5]  = '{C_OP_DIV,   32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1,  0};
    vecs[6]  = '{C_OP_DIV,   32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 34, 0};
    vecs[7]  = '{C_OP_SMULL, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000,  32'h4000_0000,  1'b0, 34, 0};
    vecs[8]  = '{C_OP_UMULL, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  32'h0000_0001,  1'b0, 34, 0};
    vecs[9]  = '{C_OP_SMULL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0000,  1'b0, 34, 0};
    vecs[10] = '{C_OP_SMULL, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFF2,  32'hFFFF_FFFF,  1'b0, 34, 0};
    vecs[11] = '{C_OP_MUL32, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  32'd0,          1'b0, 34, 0};
    vecs[12] = '{C_OP_DIV,   32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 34, 0};
    vecs[13] = '{C_OP_DIV,   32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 34, 0};
    vecs[14] = '{C_OP_UMULL, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000,  32'h4000_0000,  1'b0, 34, 0};

    bus.start = 1'b0; bus.ALUControl = 4'd0; bus.SrcA = 32'd0; bus.SrcB = 32'd0;
    reset = 1'b1;
    #3;
    chk("reset.state", {bus.busy, bus.done, bus.DivByZero, bus.ResultHi, bus.ResultLo}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start held through the DONE cycle is ignored there, accepted one cycle later.
    issue(C_OP_MUL32, 32'd2, 32'd3);
    wait_done(0, lat, busy_ok);
    chk("b2b.first_latency", 64'(lat), 64'd34);
    bus.start = 1'b1; bus.ALUControl = C_OP_MUL32; bus.SrcA = 32'd4; bus.SrcB = 32'd5;
    @(posedge clk); #1;
    chk("b2b.ignored_in_done", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("b2b.first_lo", {32'd0, bus.ResultLo}, 64'd6);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b.accepted", {63'd0, bus.busy}, 64'd1);
    wait_done(0, lat, busy_ok);
    chk("b2b.second_latency", 64'(lat), 64'd34);
    chk("b2b.second_lo", {32'd0, bus.ResultLo}, 64'd20);
    @(posedge clk); #1;

    // Unsupported opcode leaves the block idle and results untouched.
    issue(4'b0000, 32'd1, 32'd1);
    chk("unsup.busy", {63'd0, bus.busy}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("unsup.quiet", {bus.busy, bus.done, bus.ResultHi, bus.ResultLo}, {2'b00, 32'd0, 32'd20});

    // Reset in the middle of a UMULL.
    issue(C_OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (14) @(posedge clk);
    #1;
    chk("rst_mid.busy_before", {63'd0, bus.busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid.async_clear", {bus.busy, bus.done, bus.DivByZero, bus.ResultHi, bus.ResultLo}, 64'd0);
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) quiet = 1'b0;
    end
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) quiet = 1'b0;
    end
    chk("rst_mid.no_done", {63'd0, quiet}, 64'd1);
    chk("rst_mid.results_zero", {bus.ResultHi, bus.ResultLo}, 64'd0);

    v = '{C_OP_MUL32, 32'd2, 32'd3, 32'd6, 32'd0, 1'b0, 34, 0};
    run_vec(v, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
